// File: rtl/byte_uart_pkg.sv
// rtl/byte_uart_pkg.sv - shared types and frame constants for the byte UART transmitter
package byte_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running bit-time counter with terminal-count tick
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_bit_timer: CLKS_PER_BIT must be at least 2");
    end

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Count 0..CLKS_PER_BIT-1 and wrap; clear realigns bit boundaries to an accept edge
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/byte_uart_tx.sv
// rtl/byte_uart_tx.sv - 8N1 UART transmitter taking one byte per valid/ready handshake
module byte_uart_tx
    import byte_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       done
);

    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    uart_state_t               state;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [IDX_W-1:0]          idx;
    logic                      tick;
    logic                      accept;

    // ready drops combinationally with rst so a byte offered during reset is never taken
    assign ready  = (state == IDLE) && !rst;
    assign accept = valid && ready;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(accept),
        .tick (tick)
    );

    // Frame sequencer: start bit, 8 data bits LSB first, stop bit; tx and done are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
            tx    <= UART_STOP_LVL;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        shreg <= data_in;
                        idx   <= '0;
                        tx    <= UART_START_LVL;
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx    <= shreg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (idx == LAST_IDX) begin
                            tx    <= UART_STOP_LVL;
                            state <= STOP;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            shreg <= shreg >> 1;
                            tx    <= shreg[1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= UART_STOP_LVL;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/byte_uart_tx.md
# byte_uart_tx

Serial output stage for the 8-bit counter design. It accepts one byte per valid/ready handshake, typically the counter value, and transmits it as an 8N1 UART frame on a single output pin. This makes the counter observable on one `uo_out` bit, and the remaining outputs stay free. It sits directly downstream of the counter and consumes its 8-bit output bus.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is ≥ 2; elaboration fails below 2.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `data_in`, input, 8: byte to send, normally the counter output. Sampled only on the accept edge.
- `valid`, input, 1: a byte is offered on `data_in`.
- `ready`, output, 1: block can accept a byte. High only in IDLE and while `rst` = 0.
- `tx`, output, 1: serial line. Idle level is 1.
- `done`, output, 1: one-cycle pulse after a frame's stop bit completes.

## Operation
- FSM states are IDLE, START, DATA and STOP.
- The frame is start bit (0), then data bits 0..7 LSB first, then stop bit (1).
- Accept occurs on a rising edge with `valid` && `ready`. At that edge:
  - the shift register loads `data_in`;
  - the bit-time counter clears;
  - the bit index clears;
  - the state moves to START;
  - `tx` loads 0.
- Bit-time counter:
  - width is $clog2(CLKS_PER_BIT);
  - counts 0..CLKS_PER_BIT-1;
  - the terminal count ends the current bit.
- Transitions at terminal count:
  - START → DATA, and `tx` takes data bit 0.
  - DATA: if the index is 7, go to STOP and set `tx` to 1. Otherwise, increment the index, shift right, and set `tx` to the next bit.
  - STOP → IDLE, and `done` goes to 1 for one cycle.
- `tx` is registered and never glitches. It equals 1 in IDLE and STOP.
- `data_in` changes after the accept edge have no effect on the frame in flight.
- `valid` while not `ready` is ignored, with no queuing. Upstream holds `valid` until accepted.
- A `valid` held continuously produces back-to-back frames. Each frame samples `data_in` at its own accept edge.

## Timing
- Reset values:
  - state is IDLE;
  - `tx` = 1;
  - `done` = 0;
  - `ready` = 0 while `rst` is high and 1 from the first cycle after `rst` falls;
  - shift register, bit index and bit-time counter are 0.
- Accept is at edge E. `tx` is 0 from E for CLKS_PER_BIT cycles.
- Data bit k occupies edges E+(k+1)·N through E+(k+2)·N, where N = CLKS_PER_BIT.
- The stop bit starts at E+9N. The state returns to IDLE at E+10N.
- `done` is high for exactly the one cycle following E+10N.
- `ready` is high from E+10N. The earliest next accept is E+10N+1, so the stop bit lasts N+1 cycles minimum between back-to-back frames.
- Reset mid-frame at any state: on the next edge, `tx` = 1, state is IDLE and `done` = 0. No partial `done`.
- `rst` and `valid` asserted together: reset wins and nothing is accepted.

## Structure
- Package `byte_uart_pkg` contains:
  - the state typedef `uart_state_t` {IDLE, START, DATA, STOP};
  - constants `UART_DATA_BITS` = 8, `UART_START_LVL` = 0, `UART_STOP_LVL` = 1.
- One sub-module is natural: `uart_bit_timer`, parameterised by CLKS_PER_BIT, with inputs `clk`, `rst` and `clear`, and output `tick` (terminal count).
- The FSM, shift register and output registers stay in `byte_uart_tx`.
- At top level, `tx` drives one `uo_out` bit, and `rst` is derived as `!rst_n`.

## Test plan
- CLKS_PER_BIT=4, reset, then a single `valid` with 0xA5. Required response:
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles;
  - `done` pulses once at accept+40;
  - `ready` is low throughout.
- Hold `valid` with 0x00 then 0xFF. Required response:
  - two frames;
  - second start edge exactly 41 cycles after the first;
  - 8 zeros then 8 ones in the data fields.
- Change `data_in` from 0x3C to 0xC3 one cycle after accept. Required response: the transmitted byte is 0x3C.
- Assert `rst` during data bit 3 of 0x5A. Required response:
  - `tx` = 1 next cycle;
  - no `done`;
  - `ready` = 1 the cycle after `rst` drops;
  - a new 0x5A frame then transmits correctly.
- `valid` held high during `rst` and `valid` pulsed mid-frame. Required response: no accept in either case and the frame in flight is unchanged.
- CLKS_PER_BIT=2 with byte 0x81. Required response: bit widths are exactly 2 cycles and the total frame is 20 cycles.
